// File: rtl/alu_pkg.sv
// Shared ALU encodings and writeback sequencer defaults.
package alu_pkg;

  localparam int ALU_DATA_W = 24;
  localparam int ALU_REG_AW = 4;

  localparam logic [2:0] ALU_AND     = 3'b000;
  localparam logic [2:0] ALU_OR      = 3'b001;
  localparam logic [2:0] ALU_ADD     = 3'b010;
  localparam logic [2:0] ALU_SLT     = 3'b011;
  localparam logic [2:0] ALU_MUL     = 3'b100;
  localparam logic [2:0] ALU_XOR     = 3'b101;
  localparam logic [2:0] ALU_SLL     = 3'b110;
  localparam logic [2:0] ALU_ILLEGAL = 3'b111;

  localparam logic [1:0] WB_IDLE   = 2'd0;
  localparam logic [1:0] WB_WRITE  = 2'd1;
  localparam logic [1:0] WB_MUL_HI = 2'd2;

endpackage

// File: rtl/alu_result_writeback.sv
// Sequences ALU results onto the register-file write port; MUL writes rd then rd+1.
// Latency: first write one cycle after accept, MUL high half one cycle later.
// Backpressure: in_ready drops only during the MUL low-half write cycle.
module alu_result_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          sel,
  input  logic [DATA_W-1:0]   res_data,
  input  logic [2*DATA_W-1:0] mul_data,
  input  logic [REG_AW-1:0]   rd_addr,
  output logic                wr_en,
  output logic [REG_AW-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                op_done,
  output logic                illegal_op
);

  localparam logic [REG_AW-1:0] REG_ONE = REG_AW'(1);

  logic [1:0]        state;
  logic [2:0]        cap_sel;
  logic [REG_AW-1:0] cap_rd;
  logic [DATA_W-1:0] cap_hi;
  logic [REG_AW-1:0] rd_hi;
  logic              accept;
  logic              in_mul_lo;
  logic              is_mul;
  logic              is_ill;

  assign in_mul_lo = (state == WB_WRITE) && (cap_sel == ALU_MUL);
  assign in_ready  = !in_mul_lo;
  assign accept    = in_valid && in_ready;
  assign is_mul    = (sel == ALU_MUL);
  assign is_ill    = (sel == ALU_ILLEGAL);
  assign rd_hi     = cap_rd + REG_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WB_IDLE;
      cap_sel    <= ALU_AND;
      cap_rd     <= '0;
      cap_hi     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      op_done    <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      op_done    <= 1'b0;
      illegal_op <= 1'b0;
      if (in_mul_lo) begin
        // High half comes from the captured copy, so input changes cannot disturb it.
        state   <= WB_MUL_HI;
        wr_addr <= rd_hi;
        wr_data <= cap_hi;
        wr_en   <= (rd_hi != '0);
        op_done <= 1'b1;
      end else if (accept) begin
        state      <= WB_WRITE;
        cap_sel    <= sel;
        cap_rd     <= rd_addr;
        cap_hi     <= mul_data[2*DATA_W-1:DATA_W];
        wr_addr    <= rd_addr;
        wr_data    <= is_mul ? mul_data[DATA_W-1:0] : res_data;
        wr_en      <= (rd_addr != '0) && !is_ill;
        op_done    <= !is_mul;
        illegal_op <= is_ill;
      end else begin
        state <= WB_IDLE;
      end
    end
  end

endmodule
